aes_seq_ctrl: RTL and testbench

Sequencer between the local-bus register file and the AES block-cipher core on the SASEBO-GIII FPGA. It loads keys, launches single or batched encryptions, and chains ciphertext to the next plaintext in batch mode. It emits a per-encryption scope trigger, supervises the core with a watchdog, and pulses the core reset on abort or timeout.

---
 rtl/aes_seq_pkg.sv | 25 ++
 rtl/aes_seq_ctrl_if.sv | 45 ++++
 rtl/aes_seq_timer.sv | 25 ++
 rtl/aes_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_aes_seq_ctrl.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_seq_pkg.sv
// Shared types and default timing constants for the AES core sequencer.
package aes_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KREQ,
    S_KWAIT,
    S_DREQ,
    S_DWAIT,
    S_CAPT,
    S_GAP,
    S_CRST
  } state_e;

  localparam logic [15:0] TMO_MAX_DEF = 16'd4095;
  localparam int unsigned GAP_CYC_DEF = 4;
  localparam int unsigned RST_CYC_DEF = 8;
  localparam int unsigned PT_W        = 128;

  // A batch length of zero still runs one encryption.
  function automatic logic [15:0] batch_len(input logic [15:0] n);
    return (n == 16'd0) ? 16'd1 : n;
  endfunction

endpackage

// File: rtl/aes_seq_ctrl_if.sv
// Host-side controls plus AES core handshake; master = host/core side, slave = sequencer.
interface aes_seq_ctrl_if
  import aes_seq_pkg::*;
#(
  parameter int unsigned DIN_W = 496
);
  logic              key_go;
  logic              enc_go;
  logic              abort;
  logic [15:0]       enc_cnt;
  logic [PT_W-1:0]   key_in;
  logic [DIN_W-1:0]  din_in;

  logic [PT_W-1:0]   blk_kin;
  logic [DIN_W-1:0]  blk_din;
  logic              blk_krdy;
  logic              blk_drdy;
  logic              blk_en;
  logic              blk_rstn;
  logic              blk_kvld;
  logic              blk_dvld;
  logic              blk_busy;
  logic [PT_W-1:0]   blk_dout;

  logic [PT_W-1:0]   dout;
  logic              dout_vld;
  logic              trig;
  logic              busy;
  logic [15:0]       done_num;
  logic              err_tmo;

  modport master (
    output key_go, enc_go, abort, enc_cnt, key_in, din_in,
    output blk_kvld, blk_dvld, blk_busy, blk_dout,
    input  blk_kin, blk_din, blk_krdy, blk_drdy, blk_en, blk_rstn,
    input  dout, dout_vld, trig, busy, done_num, err_tmo
  );

  modport slave (
    input  key_go, enc_go, abort, enc_cnt, key_in, din_in,
    input  blk_kvld, blk_dvld, blk_busy, blk_dout,
    output blk_kin, blk_din, blk_krdy, blk_drdy, blk_en, blk_rstn,
    output dout, dout_vld, trig, busy, done_num, err_tmo
  );
endinterface

// File: rtl/aes_seq_timer.sv
// Loadable 16-bit down-counter that stops at zero; load has priority over counting.
// Zero flag is combinational from the count, so a load of N gives N+1 cycles until zero is seen.
module aes_seq_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [15:0] i_val,
  output logic        o_zero
);

  logic [15:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != 16'd0) begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  assign o_zero = (r_cnt == 16'd0);

endmodule

// File: rtl/aes_seq_ctrl.sv
// Sequencer between the register file and the AES core: key load, batched chained encryption, watchdog, core reset.
// Strobes are one cycle after the request; data strobe waits while the core reports busy.
module aes_seq_ctrl
  import aes_seq_pkg::*;
#(
  parameter int unsigned DIN_W   = 496,
  parameter logic [15:0] TMO_MAX = TMO_MAX_DEF,
  parameter int unsigned GAP_CYC = GAP_CYC_DEF,
  parameter int unsigned RST_CYC = RST_CYC_DEF
) (
  input logic           clk,
  input logic           rst,
  aes_seq_ctrl_if.slave bus
);

  state_e            r_state;
  state_e            w_next;
  logic [PT_W-1:0]   r_kin;
  logic [DIN_W-1:0]  r_din;
  logic [PT_W-1:0]   r_dout;
  logic [15:0]       r_len;
  logic [15:0]       r_done;
  logic              r_pend;
  logic              r_tmo;
  logic              r_blk_on;

  logic              w_tmr_load;
  logic [15:0]       w_tmr_val;
  logic              w_tmr_zero;
  logic              w_key_acc;
  logic              w_enc_latch;
  logic              w_start;
  logic              w_capt;
  logic              w_timeout;

  aes_seq_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_tmr_load),
    .i_val  (w_tmr_val),
    .o_zero (w_tmr_zero)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (r_pend)           w_next = S_DREQ;
        else if (bus.key_go)  w_next = S_KREQ;
        else if (bus.enc_go)  w_next = S_DREQ;
      end
      S_KREQ:  w_next = S_KWAIT;
      S_KWAIT: begin
        if (bus.blk_kvld)     w_next = S_IDLE;
        else if (w_tmr_zero)  w_next = S_CRST;
      end
      S_DREQ: begin
        if (!bus.blk_busy)    w_next = S_DWAIT;
      end
      // A ciphertext arriving on the last watchdog cycle still wins.
      S_DWAIT: begin
        if (bus.blk_dvld)     w_next = S_CAPT;
        else if (w_tmr_zero)  w_next = S_CRST;
      end
      S_CAPT:  w_next = (r_done == r_len) ? S_IDLE : S_GAP;
      S_GAP: begin
        if (w_tmr_zero)       w_next = S_DREQ;
      end
      S_CRST: begin
        if (w_tmr_zero)       w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (bus.abort && (r_state != S_CRST)) w_next = S_CRST;
  end

  // Watchdog load leaves TMO_MAX cycles from the request strobe to the CRST entry.
  always_comb begin
    w_tmr_load = (w_next != r_state);
    w_tmr_val  = 16'd0;
    unique case (w_next)
      S_KWAIT, S_DWAIT: w_tmr_val = TMO_MAX - 16'd2;
      S_GAP:            w_tmr_val = 16'(GAP_CYC - 1);
      S_CRST:           w_tmr_val = 16'(RST_CYC - 1);
      default:          w_tmr_val = 16'd0;
    endcase
  end

  assign w_key_acc   = (r_state == S_IDLE) && !r_pend && (w_next == S_KREQ);
  assign w_enc_latch = (r_state == S_IDLE) && !r_pend && bus.enc_go &&
                       (w_next inside {S_KREQ, S_DREQ});
  assign w_start     = (r_state == S_IDLE) && (w_next == S_DREQ);
  assign w_capt      = (r_state == S_DWAIT) && (w_next == S_CAPT);
  assign w_timeout   = ((r_state == S_KWAIT) || (r_state == S_DWAIT)) &&
                       (w_next == S_CRST) && !bus.abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_kin    <= '0;
      r_din    <= '0;
      r_dout   <= '0;
      r_len    <= '0;
      r_done   <= '0;
      r_pend   <= 1'b0;
      r_tmo    <= 1'b0;
      r_blk_on <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_blk_on <= (w_next != S_CRST);
      if (w_key_acc) begin
        r_kin <= bus.key_in;
        r_tmo <= 1'b0;
      end
      // A data request that loses to a key load is latched now and replayed from IDLE.
      if (w_enc_latch) begin
        r_din <= bus.din_in;
        r_len <= batch_len(bus.enc_cnt);
        r_tmo <= 1'b0;
      end
      if (w_key_acc && bus.enc_go) r_pend <= 1'b1;
      if (w_start) begin
        r_done <= '0;
        r_pend <= 1'b0;
      end
      if (w_capt) begin
        r_dout            <= bus.blk_dout;
        r_din[PT_W-1:0]   <= bus.blk_dout;
        r_done            <= r_done + 16'd1;
      end
      // The core loses its key in CRST, so a deferred encryption is meaningless afterwards.
      if (w_next == S_CRST) r_pend <= 1'b0;
      if (w_timeout)        r_tmo  <= 1'b1;
    end
  end

  assign bus.blk_kin  = r_kin;
  assign bus.blk_din  = r_din;
  assign bus.blk_krdy = (r_state == S_KREQ) && !bus.abort;
  assign bus.blk_drdy = (r_state == S_DREQ) && !bus.blk_busy && !bus.abort;
  assign bus.trig     = bus.blk_drdy;
  assign bus.blk_en   = r_blk_on;
  assign bus.blk_rstn = r_blk_on;
  assign bus.dout     = r_dout;
  assign bus.dout_vld = (r_state == S_CAPT);
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done_num = r_done;
  assign bus.err_tmo  = r_tmo;

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Bench for aes_seq_ctrl: behavioural AES core stand-in, event logger and per-scenario tasks.
module tb_aes_seq_ctrl;

  localparam int unsigned DIN_W = 496;
  localparam int GAP  = 4;
  localparam int RSTC = 8;
  localparam int TMO  = 4095;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  aes_seq_ctrl_if #(.DIN_W(DIN_W)) bus ();

  aes_seq_ctrl #(
    .DIN_W   (DIN_W),
    .TMO_MAX (16'd4095),
    .GAP_CYC (4),
    .RST_CYC (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core stand-in and event logs
  int  core_lat  = 6;
  int  key_lat   = 10;
  bit  core_mute = 1'b0;
  logic [127:0] core_key = '0;
  logic [127:0] pend_ct  = '0;
  int  kcnt = 0;
  int  dcnt = 0;

  int               krdy_q[$];
  int               trig_q[$];
  logic [DIN_W-1:0] din_q[$];
  logic [127:0]     dv_q[$];
  int               dvc_q[$];
  int               tmo_cyc = -1;
  bit               tmo_prev = 1'b0;
  int               rstn_low = 0;
  int               rstn_start = -1;

  function automatic logic [127:0] core_enc(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return {p[94:0], p[127:95]} ^ k ^ 128'ha5a5_3c3c_0f0f_9696_5a5a_c3c3_f0f0_6969;
  endfunction

  initial begin : core_model
    bus.blk_kvld = 1'b0;
    bus.blk_dvld = 1'b0;
    bus.blk_busy = 1'b0;
    bus.blk_dout = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.blk_krdy) krdy_q.push_back(cyc);
        if (bus.trig) begin
          trig_q.push_back(cyc);
          din_q.push_back(bus.blk_din);
        end
        if (bus.dout_vld) begin
          dv_q.push_back(bus.dout);
          dvc_q.push_back(cyc);
        end
        if (bus.err_tmo && !tmo_prev) tmo_cyc = cyc;
        if (!bus.blk_rstn) begin
          if (rstn_low == 0) rstn_start = cyc;
          rstn_low++;
        end
      end
      tmo_prev = bus.err_tmo;
      bus.blk_kvld = 1'b0;
      bus.blk_dvld = 1'b0;
      if (rst || !bus.blk_rstn) begin
        kcnt = 0;
        dcnt = 0;
        bus.blk_busy = 1'b0;
      end else begin
        if (kcnt > 0) begin
          kcnt--;
          if (kcnt == 0) bus.blk_kvld = 1'b1;
        end
        if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0 && !core_mute) begin
            bus.blk_dvld = 1'b1;
            bus.blk_dout = pend_ct;
          end
        end
        bus.blk_busy = (dcnt > 0);
        if (bus.blk_krdy) begin
          core_key = bus.blk_kin;
          kcnt = key_lat;
        end
        if (bus.blk_drdy) begin
          pend_ct = core_enc(core_key, bus.blk_din[127:0]);
          dcnt = core_lat;
        end
      end
    end
  end

  initial begin : global_guard
    #900000;
    $display("FAIL global_timeout: still running at %0t, required to finish earlier", $time);
    $fatal(1, "simulation did not finish");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    krdy_q.delete();
    trig_q.delete();
    din_q.delete();
    dv_q.delete();
    dvc_q.delete();
    tmo_cyc = -1;
    rstn_low = 0;
    rstn_start = -1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [DIN_W-1:0] rand_din();
    logic [DIN_W-1:0] v;
    for (int i = 0; i < int'(DIN_W); i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic go(input bit kg, input bit eg, input logic [127:0] k,
                    input logic [DIN_W-1:0] d, input logic [15:0] n, output int c);
    tick();
    bus.key_in  = k;
    bus.din_in  = d;
    bus.enc_cnt = n;
    bus.key_go  = kg;
    bus.enc_go  = eg;
    c = cyc;
    tick();
    bus.key_go = 1'b0;
    bus.enc_go = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int idle_cyc);
    idle_cyc = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (!bus.busy) begin
        idle_cyc = cyc;
        break;
      end
    end
    if (idle_cyc < 0) begin
      total++;
      bad++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", limit);
    end
  endtask

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc < target && guard < 10000) begin
      tick();
      guard++;
    end
    total++;
    if (cyc != target) begin
      bad++;
      $display("FAIL wait_cyc: reached cycle %0d, required %0d", cyc, target);
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    int c, ic;
    go(1'b1, 1'b0, k, '0, 16'd0, c);
    wait_idle(200, ic);
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++;
    if ({bus.busy, bus.blk_krdy, bus.blk_drdy, bus.trig, bus.dout_vld, bus.err_tmo,
         bus.blk_en, bus.blk_rstn} !== 8'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b, required 00000000",
               {bus.busy, bus.blk_krdy, bus.blk_drdy, bus.trig, bus.dout_vld, bus.err_tmo,
                bus.blk_en, bus.blk_rstn});
    end
    total++;
    if (bus.blk_kin !== '0 || bus.blk_din !== '0 || bus.dout !== '0 || bus.done_num !== 16'd0) begin
      bad++;
      $display("FAIL reset_data: kin=%0h din_lo=%0h dout=%0h done=%0d, required all 0",
               bus.blk_kin, bus.blk_din[127:0], bus.dout, bus.done_num);
    end
    rst = 1'b0;
    #1;
    total++;
    if (bus.blk_rstn !== 1'b0) begin
      bad++;
      $display("FAIL reset_rstn_before_clk: got %b, required 0", bus.blk_rstn);
    end
    tick();
    total++;
    if (bus.blk_rstn !== 1'b1 || bus.blk_en !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: rstn=%b en=%b busy=%b, required 1 1 0",
               bus.blk_rstn, bus.blk_en, bus.busy);
    end
  endtask

  task automatic test_key_load();
    int c, ic;
    key_lat = 10;
    clear_logs();
    go(1'b1, 1'b0, FIPS_KEY, '0, 16'd0, c);
    wait_idle(100, ic);
    total++;
    if (krdy_q.size() != 1 || krdy_q[0] != c + 1) begin
      bad++;
      $display("FAIL key_krdy: pulses=%0d first=%0d, required 1 pulse at %0d",
               krdy_q.size(), (krdy_q.size() > 0) ? krdy_q[0] : -1, c + 1);
    end
    total++;
    if (ic != c + 12) begin
      bad++;
      $display("FAIL key_idle_cycle: got %0d, required %0d", ic, c + 12);
    end
    total++;
    if (bus.err_tmo !== 1'b0 || bus.blk_kin !== FIPS_KEY) begin
      bad++;
      $display("FAIL key_state: err_tmo=%b kin=%0h, required 0 %0h", bus.err_tmo, bus.blk_kin, FIPS_KEY);
    end
  endtask

  task automatic test_single_fips();
    int c, ic;
    logic [DIN_W-1:0] d;
    core_lat = $urandom_range(3, 12);
    d = rand_din();
    d[127:0] = FIPS_PT;
    clear_logs();
    go(1'b0, 1'b1, '0, d, 16'd0, c);
    wait_idle(100, ic);
    total++;
    if (trig_q.size() != 1 || trig_q[0] != c + 1) begin
      bad++;
      $display("FAIL single_trig: pulses=%0d first=%0d, required 1 pulse at %0d",
               trig_q.size(), (trig_q.size() > 0) ? trig_q[0] : -1, c + 1);
    end
    total++;
    if (dv_q.size() != 1 || dv_q[0] !== FIPS_CT) begin
      bad++;
      $display("FAIL single_dout: pulses=%0d dout=%0h, required 1 pulse %0h",
               dv_q.size(), bus.dout, FIPS_CT);
    end
    total++;
    if (dvc_q.size() != 1 || dvc_q[0] != c + core_lat + 2) begin
      bad++;
      $display("FAIL single_dout_vld_cycle: got %0d, required %0d",
               (dvc_q.size() > 0) ? dvc_q[0] : -1, c + core_lat + 2);
    end
    total++;
    if (bus.done_num !== 16'd1 || bus.dout !== FIPS_CT) begin
      bad++;
      $display("FAIL single_final: done=%0d dout=%0h, required 1 %0h", bus.done_num, bus.dout, FIPS_CT);
    end
  endtask

  task automatic test_batch_chain();
    int c, ic, m, per;
    logic [127:0] key, pt, ct;
    logic [DIN_W-1:0] d, exp_din;
    logic [15:0] n;
    for (int it = 0; it < 4; it++) begin
      key_lat = $urandom_range(2, 15);
      key = rand128();
      load_key(key);
      core_lat = $urandom_range(3, 12);
      per = core_lat + GAP + 2;
      d = rand_din();
      n = (it == 0) ? 16'd3 : 16'($urandom_range(0, 4));
      m = (n == 16'd0) ? 1 : int'(n);
      clear_logs();
      go(1'b0, 1'b1, '0, d, n, c);
      wait_idle(m * per + 30, ic);
      total++;
      if (dv_q.size() != m || trig_q.size() != m) begin
        bad++;
        $display("FAIL batch_count: dout_vld=%0d trig=%0d, required %0d", dv_q.size(), trig_q.size(), m);
      end
      pt = d[127:0];
      exp_din = d;
      for (int i = 0; i < m; i++) begin
        exp_din[127:0] = pt;
        ct = core_enc(key, pt);
        if (i < trig_q.size()) begin
          total++;
          if (trig_q[i] != c + 1 + i * per) begin
            bad++;
            $display("FAIL batch_trig_cycle[%0d]: got %0d, required %0d", i, trig_q[i], c + 1 + i * per);
          end
          total++;
          if (din_q[i] !== exp_din) begin
            bad++;
            $display("FAIL batch_din[%0d]: got lo=%0h hi=%0h, required lo=%0h hi=%0h", i,
                     din_q[i][127:0], din_q[i][DIN_W-1:128], exp_din[127:0], exp_din[DIN_W-1:128]);
          end
        end
        if (i < dv_q.size()) begin
          total++;
          if (dv_q[i] !== ct) begin
            bad++;
            $display("FAIL batch_dout[%0d]: got %0h, required %0h", i, dv_q[i], ct);
          end
        end
        pt = ct;
      end
      total++;
      if (bus.done_num !== 16'(m)) begin
        bad++;
        $display("FAIL batch_done_num: got %0d, required %0d", bus.done_num, m);
      end
    end
  endtask

  task automatic test_timeout();
    int c, ic, t;
    core_mute = 1'b1;
    core_lat = 5;
    clear_logs();
    go(1'b0, 1'b1, '0, rand_din(), 16'd1, c);
    t = c + 1;
    wait_idle(TMO + 100, ic);
    total++;
    if (tmo_cyc != t + TMO) begin
      bad++;
      $display("FAIL tmo_cycle: got %0d, required %0d", tmo_cyc, t + TMO);
    end
    total++;
    if (rstn_low != RSTC || rstn_start != t + TMO) begin
      bad++;
      $display("FAIL tmo_rstn: low=%0d start=%0d, required %0d at %0d", rstn_low, rstn_start, RSTC, t + TMO);
    end
    total++;
    if (bus.err_tmo !== 1'b1 || dv_q.size() != 0) begin
      bad++;
      $display("FAIL tmo_sticky: err_tmo=%b captures=%0d, required 1 0", bus.err_tmo, dv_q.size());
    end
    core_mute = 1'b0;
    go(1'b0, 1'b1, '0, rand_din(), 16'd1, c);
    total++;
    if (bus.err_tmo !== 1'b0) begin
      bad++;
      $display("FAIL tmo_clear: got %b, required 0", bus.err_tmo);
    end
    wait_idle(100, ic);
  endtask

  task automatic test_abort();
    int c, ic, t0, a;
    logic [127:0] prev;
    load_key(rand128());
    core_lat = $urandom_range(6, 10);
    clear_logs();
    go(1'b0, 1'b1, '0, rand_din(), 16'd5, c);
    t0 = c + 1;
    a = t0 + (core_lat + GAP + 2) + 2;
    wait_cyc(a);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    wait_idle(100, ic);
    total++;
    if (dv_q.size() != 1 || trig_q.size() != 2 || bus.done_num !== 16'd1) begin
      bad++;
      $display("FAIL abort_mid_batch: captures=%0d trigs=%0d done=%0d, required 1 2 1",
               dv_q.size(), trig_q.size(), bus.done_num);
    end
    total++;
    if (rstn_low != RSTC || rstn_start != a + 1) begin
      bad++;
      $display("FAIL abort_rstn: low=%0d start=%0d, required %0d at %0d", rstn_low, rstn_start, RSTC, a + 1);
    end
    load_key(rand128());
    prev = bus.dout;
    clear_logs();
    go(1'b0, 1'b1, '0, rand_din(), 16'd2, c);
    a = c + 1 + core_lat;
    wait_cyc(a);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    wait_idle(100, ic);
    total++;
    if (dv_q.size() != 0 || bus.done_num !== 16'd0 || bus.dout !== prev) begin
      bad++;
      $display("FAIL abort_vs_dvld: captures=%0d done=%0d dout=%0h, required 0 0 %0h",
               dv_q.size(), bus.done_num, bus.dout, prev);
    end
  endtask

  task automatic test_simul_go_then_rst();
    int c, t;
    logic [127:0] k;
    logic [DIN_W-1:0] d;
    key_lat = 5;
    core_lat = 20;
    k = rand128();
    d = rand_din();
    clear_logs();
    go(1'b1, 1'b1, k, d, 16'd1, c);
    t = c + 3 + key_lat;
    wait_cyc(t + 2);
    total++;
    if (krdy_q.size() != 1 || krdy_q[0] != c + 1 || trig_q.size() != 1 || trig_q[0] != t) begin
      bad++;
      $display("FAIL simul_order: krdy=%0d trig=%0d, required krdy at %0d trig at %0d",
               (krdy_q.size() > 0) ? krdy_q[0] : -1, (trig_q.size() > 0) ? trig_q[0] : -1, c + 1, t);
    end
    total++;
    if (din_q.size() != 1 || din_q[0] !== d || bus.blk_kin !== k) begin
      bad++;
      $display("FAIL simul_latch: din_lo=%0h kin=%0h, required %0h %0h",
               (din_q.size() > 0) ? din_q[0][127:0] : 128'h0, bus.blk_kin, d[127:0], k);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({bus.busy, bus.blk_krdy, bus.blk_drdy, bus.trig, bus.dout_vld, bus.err_tmo,
         bus.blk_en, bus.blk_rstn} !== 8'b0) begin
      bad++;
      $display("FAIL async_rst_flags: got %b, required 00000000",
               {bus.busy, bus.blk_krdy, bus.blk_drdy, bus.trig, bus.dout_vld, bus.err_tmo,
                bus.blk_en, bus.blk_rstn});
    end
    total++;
    if (bus.blk_kin !== '0 || bus.blk_din !== '0 || bus.dout !== '0 || bus.done_num !== 16'd0) begin
      bad++;
      $display("FAIL async_rst_data: kin=%0h din_lo=%0h dout=%0h done=%0d, required all 0",
               bus.blk_kin, bus.blk_din[127:0], bus.dout, bus.done_num);
    end
    tick();
    rst = 1'b0;
    repeat (2) tick();
  endtask

  initial begin : main
    bus.key_go  = 1'b0;
    bus.enc_go  = 1'b0;
    bus.abort   = 1'b0;
    bus.enc_cnt = '0;
    bus.key_in  = '0;
    bus.din_in  = '0;
    test_reset();
    test_key_load();
    test_single_fips();
    test_batch_chain();
    test_timeout();
    test_abort();
    test_simul_go_then_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
